// File: rtl/ame_normal_accumulate_pkg.sv
// rtl/ame_normal_accumulate_pkg.sv - shared state type and index maps for the AME normal-equation accumulator
//
// Purpose: types and constants shared by ame_normal_accumulate and its MAC array.
//   ame_state_e      : accumulator FSM states (IDLE / ACCUM / FLUSH)
//   TRI_ROW/TRI_COL  : the 21 upper-triangle (i,j) pairs, i <= j, row-major
//   tri_index(i,j)   : position of A_ij (either triangle) in that list
// No ports (package).

package ame_normal_accumulate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2
  } ame_state_e;

  localparam int unsigned NUM_COEF = 6;
  localparam int unsigned NUM_TRI  = 21;
  localparam int unsigned NUM_MAC  = NUM_TRI + NUM_COEF;

  // Row-major walk of the upper triangle: (0,0)(0,1)..(0,5)(1,1)..(5,5).
  localparam int unsigned TRI_ROW [NUM_TRI] = '{
    0, 0, 0, 0, 0, 0,
    1, 1, 1, 1, 1,
    2, 2, 2, 2,
    3, 3, 3,
    4, 4,
    5
  };

  localparam int unsigned TRI_COL [NUM_TRI] = '{
    0, 1, 2, 3, 4, 5,
    1, 2, 3, 4, 5,
    2, 3, 4, 5,
    3, 4, 5,
    4, 5,
    5
  };

  // Inverse of the map above; arguments are symmetric so the lower
  // triangle resolves to its upper-triangle partner.
  function automatic int tri_index(input int i, input int j);
    int r;
    int c;
    r = (i < j) ? i : j;
    c = (i < j) ? j : i;
    return r * 6 - (r * (r - 1)) / 2 + (c - r);
  endfunction

endpackage

// File: rtl/ame_num_mac.sv
// rtl/ame_num_mac.sv - one signed multiply, product register and wrapping accumulator
//
// Purpose: one matrix element of the normal-equation accumulator.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clr_i          : synchronous clear of product and accumulator (wins over enables)
//   mul_en_i       : capture op_a_i * op_b_i into the product register
//   acc_en_i       : add the sign-extended product register into the accumulator
//   op_a_i, op_b_i : signed operands, SAMP_DATA_BITS each
//   acc_o          : accumulator, COMP_DATA_BITS two's complement, wraps on overflow

module ame_num_mac #(
  parameter int SAMP_DATA_BITS = 16,
  parameter int COMP_DATA_BITS = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             clr_i,
  input  logic                             mul_en_i,
  input  logic                             acc_en_i,
  input  logic signed [SAMP_DATA_BITS-1:0] op_a_i,
  input  logic signed [SAMP_DATA_BITS-1:0] op_b_i,
  output logic        [COMP_DATA_BITS-1:0] acc_o
);

  localparam int PROD_BITS = 2 * SAMP_DATA_BITS;

  logic signed [PROD_BITS-1:0]      prod_d, prod_q;
  logic signed [COMP_DATA_BITS-1:0] prod_ext;
  logic signed [COMP_DATA_BITS-1:0] acc_d, acc_q;

  // Operands widened first so the full signed product is kept.
  assign prod_d   = PROD_BITS'(op_a_i) * PROD_BITS'(op_b_i);
  assign prod_ext = COMP_DATA_BITS'(prod_q);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prod_q <= '0;
    end else if (clr_i) begin
      prod_q <= '0;
    end else if (mul_en_i) begin
      prod_q <= prod_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/ame_normal_accumulate.sv
// rtl/ame_normal_accumulate.sv - accumulates the 6x7 augmented normal-equation matrix for affine motion estimation
//
// Purpose: A += a*a^T, B += a*b over a block of sample beats; the result is
// held stable from the comp_done_o pulse until the next comp_init_i.
// Ports:
//   clk_i, rst_n_i   : clock, asynchronous active-low reset
//   comp_init_i      : clear everything, latch mode, enter ACCUM (any state)
//   comp_done_o      : one-cycle pulse once comp_data_o is final
//   affine_param6_i  : 1 = 6-parameter, 0 = 4-parameter; sampled on comp_init_i
//   affine_param6_o  : latched mode
//   samp_valid_i/samp_ready_o/samp_last_i : sample beat handshake
//   samp_coef_i      : signed coefficients a0..a5
//   samp_resd_i      : signed residual b
//   samp_cnt_o       : accepted beats, saturating
//   comp_data_o      : [i][j<6] = A_ij, [i][6] = B_i

module ame_normal_accumulate
  import ame_normal_accumulate_pkg::*;
#(
  parameter int COMP_DATA_BITS = 64,
  parameter int SAMP_DATA_BITS = 16,
  parameter int SAMP_CNT_BITS  = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic                                  comp_init_i,
  output logic                                  comp_done_o,
  input  logic                                  affine_param6_i,
  output logic                                  affine_param6_o,
  input  logic                                  samp_valid_i,
  output logic                                  samp_ready_o,
  input  logic                                  samp_last_i,
  input  logic [5:0][SAMP_DATA_BITS-1:0]        samp_coef_i,
  input  logic [SAMP_DATA_BITS-1:0]             samp_resd_i,
  output logic [SAMP_CNT_BITS-1:0]              samp_cnt_o,
  output logic [5:0][6:0][COMP_DATA_BITS-1:0]   comp_data_o
);

  ame_state_e               state_d, state_q;
  logic                     mode_d, mode_q;
  logic                     done_d, done_q;
  logic                     vld_d, vld_q;
  logic [SAMP_CNT_BITS-1:0] cnt_d, cnt_q;
  logic                     accept;

  logic signed [SAMP_DATA_BITS-1:0] coef_m [NUM_COEF];
  logic signed [SAMP_DATA_BITS-1:0] resd_s;
  logic        [COMP_DATA_BITS-1:0] acc [NUM_MAC];

  // Init has priority: a beat presented alongside it is never accepted.
  assign samp_ready_o = (state_q == ST_ACCUM) && !comp_init_i;
  assign accept       = samp_valid_i && samp_ready_o;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_ACCUM: if (accept && samp_last_i) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (comp_init_i) begin
      state_d = ST_ACCUM;
    end

    // FLUSH covers the one cycle the last product spends in the MAC
    // pipeline, so the pulse lands with the final accumulator values.
    done_d = (state_q == ST_FLUSH) && !comp_init_i;

    // accept is already low under comp_init_i, which drops in-flight products.
    vld_d  = accept;
    mode_d = comp_init_i ? affine_param6_i : mode_q;

    cnt_d = cnt_q;
    if (comp_init_i) begin
      cnt_d = '0;
    end else if (accept && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign comp_done_o     = done_q;
  assign affine_param6_o = mode_q;
  assign samp_cnt_o      = cnt_q;
  assign resd_s          = samp_resd_i;

  // 4-parameter model: lanes 0 and 1 forced to zero, so their rows,
  // columns and B entries never move off zero.
  for (genvar l = 0; l < NUM_COEF; l++) begin : g_lane
    if (l < 2) begin : g_masked
      assign coef_m[l] = mode_q ? samp_coef_i[l] : '0;
    end else begin : g_plain
      assign coef_m[l] = samp_coef_i[l];
    end
  end

  // MACs 0..20 hold the upper triangle of A, 21..26 hold B0..B5.
  for (genvar k = 0; k < NUM_MAC; k++) begin : g_mac
    logic signed [SAMP_DATA_BITS-1:0] op_a, op_b;
    if (k < NUM_TRI) begin : g_a
      assign op_a = coef_m[TRI_ROW[k]];
      assign op_b = coef_m[TRI_COL[k]];
    end else begin : g_b
      assign op_a = coef_m[k - NUM_TRI];
      assign op_b = resd_s;
    end

    ame_num_mac #(
      .SAMP_DATA_BITS (SAMP_DATA_BITS),
      .COMP_DATA_BITS (COMP_DATA_BITS)
    ) u_mac (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .clr_i    (comp_init_i),
      .mul_en_i (accept),
      .acc_en_i (vld_q),
      .op_a_i   (op_a),
      .op_b_i   (op_b),
      .acc_o    (acc[k])
    );
  end

  // Lower triangle is a mirror of the upper one.
  for (genvar i = 0; i < 6; i++) begin : g_row
    for (genvar j = 0; j < 6; j++) begin : g_col
      localparam int K = tri_index(i, j);
      assign comp_data_o[i][j] = acc[K];
    end
    assign comp_data_o[i][6] = acc[NUM_TRI + i];
  end

endmodule

// File: tb/tb_ame_normal_accumulate.sv
// tb/tb_ame_normal_accumulate.sv - table-driven and scoreboard bench for ame_normal_accumulate
`timescale 1ns/1ps

module tb_ame_normal_accumulate;

  localparam int CW = 64;
  localparam int SW = 16;
  localparam int NW = 4;
  localparam int CNT_MAX = (1 << NW) - 1;

  logic                      clk_i = 1'b0;
  logic                      rst_n_i;
  logic                      comp_init_i;
  logic                      comp_done_o;
  logic                      affine_param6_i;
  logic                      affine_param6_o;
  logic                      samp_valid_i;
  logic                      samp_ready_o;
  logic                      samp_last_i;
  logic [5:0][SW-1:0]        samp_coef_i;
  logic [SW-1:0]             samp_resd_i;
  logic [NW-1:0]             samp_cnt_o;
  logic [5:0][6:0][CW-1:0]   comp_data_o;

  ame_normal_accumulate #(
    .COMP_DATA_BITS (CW),
    .SAMP_DATA_BITS (SW),
    .SAMP_CNT_BITS  (NW)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .comp_init_i     (comp_init_i),
    .comp_done_o     (comp_done_o),
    .affine_param6_i (affine_param6_i),
    .affine_param6_o (affine_param6_o),
    .samp_valid_i    (samp_valid_i),
    .samp_ready_o    (samp_ready_o),
    .samp_last_i     (samp_last_i),
    .samp_coef_i     (samp_coef_i),
    .samp_resd_i     (samp_resd_i),
    .samp_cnt_o      (samp_cnt_o),
    .comp_data_o     (comp_data_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;
  int done_count = 0;

  typedef struct packed {
    logic [41:0][CW-1:0] m;
    logic [NW-1:0]       cnt;
    logic                mode;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   last_exp;
  longint mdl [42];
  int     mdl_cnt;
  bit     mdl_mode;

  typedef struct {
    bit                 mode;
    logic [5:0][SW-1:0] a;
    int                 b;
    longint             e_a00, e_a25, e_a55, e_a22, e_b0, e_b3, e_b5;
  } vec_t;

  vec_t vt [3];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [5:0][SW-1:0] mk(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5);
    logic [5:0][SW-1:0] v;
    v[0] = SW'(a0); v[1] = SW'(a1); v[2] = SW'(a2);
    v[3] = SW'(a3); v[4] = SW'(a4); v[5] = SW'(a5);
    return v;
  endfunction

  function automatic longint el(input int i, input int j);
    return longint'($signed(comp_data_o[i][j]));
  endfunction

  function automatic int mism(input exp_t e, output int first);
    int n;
    n = 0;
    first = 0;
    for (int k = 0; k < 42; k++) begin
      if (comp_data_o[k / 7][k % 7] !== e.m[k]) begin
        if (n == 0) first = k;
        n++;
      end
    end
    return n;
  endfunction

  function automatic int nonzero();
    int n;
    n = 0;
    for (int k = 0; k < 42; k++) if (comp_data_o[k / 7][k % 7] !== '0) n++;
    return n;
  endfunction

  task automatic mdl_clear(input bit mode);
    for (int k = 0; k < 42; k++) mdl[k] = 0;
    mdl_cnt  = 0;
    mdl_mode = mode;
  endtask

  task automatic mdl_add(input logic [5:0][SW-1:0] a, input logic [SW-1:0] b);
    longint av [6];
    longint bv;
    bv = longint'($signed(b));
    for (int i = 0; i < 6; i++) av[i] = (!mdl_mode && i < 2) ? 0 : longint'($signed(a[i]));
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) mdl[i * 7 + j] = mdl[i * 7 + j] + av[i] * av[j];
      mdl[i * 7 + 6] = mdl[i * 7 + 6] + av[i] * bv;
    end
    if (mdl_cnt < CNT_MAX) mdl_cnt++;
  endtask

  task automatic mdl_push();
    exp_t e;
    for (int k = 0; k < 42; k++) e.m[k] = mdl[k];
    e.cnt  = NW'(mdl_cnt);
    e.mode = mdl_mode;
    sb_q.push_back(e);
    last_exp = e;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_init(input bit mode);
    comp_init_i = 1'b1;
    affine_param6_i = mode;
    cyc(1);
    comp_init_i = 1'b0;
    affine_param6_i = 1'b0;
    mdl_clear(mode);
  endtask

  // Presents one beat for one edge; model updated only if the DUT took it.
  task automatic send_beat(input logic [5:0][SW-1:0] a, input logic [SW-1:0] b,
                           input bit last, input bit push);
    bit took;
    samp_valid_i = 1'b1;
    samp_coef_i  = a;
    samp_resd_i  = b;
    samp_last_i  = last;
    #1;
    took = samp_ready_o;
    chk("beat_ready", samp_ready_o, 1);
    cyc(1);
    samp_valid_i = 1'b0;
    samp_last_i  = 1'b0;
    if (took) begin
      mdl_add(a, b);
      if (last && push) mdl_push();
    end
  endtask

  // Called one step after the edge that accepted the last beat.
  task automatic wait_done();
    chk("done_early", comp_done_o, 0);
    cyc(1);
    chk("done_pulse", comp_done_o, 1);
  endtask

  exp_t mon_e;
  int   mon_nb;
  int   mon_fk;

  always @(posedge clk_i) begin
    #2;
    if (comp_done_o === 1'b1) begin
      done_count++;
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got pulse, expected none");
      end else begin
        mon_e  = sb_q.pop_front();
        mon_nb = mism(mon_e, mon_fk);
        n_total++;
        if (mon_nb == 0) n_pass++;
        else $display("FAIL sb_matrix: %0d wrong, first [%0d][%0d] got %0d expected %0d",
                      mon_nb, mon_fk / 7, mon_fk % 7,
                      $signed(comp_data_o[mon_fk / 7][mon_fk % 7]), $signed(mon_e.m[mon_fk]));
        chk("sb_cnt", samp_cnt_o, mon_e.cnt);
        chk("sb_mode", affine_param6_o, mon_e.mode);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int dc;
    int fk;
    rst_n_i = 1'b0;
    comp_init_i = 1'b0;
    affine_param6_i = 1'b0;
    samp_valid_i = 1'b0;
    samp_last_i = 1'b0;
    samp_coef_i = '0;
    samp_resd_i = '0;
    mdl_clear(1'b0);

    vt[0] = '{1'b1, mk(1, 2, 3, 4, 5, 6), 7, 1, 18, 36, 9, 7, 28, 42};
    vt[1] = '{1'b0, mk(1, 2, 3, 4, 5, 6), 7, 0, 18, 36, 9, 0, 28, 42};
    vt[2] = '{1'b1, mk(-3, 5, -7, 2, 0, -1), -4, 9, 7, 1, 49, 12, -8, 4};

    // Reset state
    cyc(2);
    chk("rst_done", comp_done_o, 0);
    chk("rst_ready", samp_ready_o, 0);
    chk("rst_mode", affine_param6_o, 0);
    chk("rst_cnt", samp_cnt_o, 0);
    chk("rst_data_nonzero", nonzero(), 0);
    rst_n_i = 1'b1;
    cyc(1);

    // Beats offered in IDLE are refused
    samp_valid_i = 1'b1;
    samp_coef_i = mk(1, 1, 1, 1, 1, 1);
    samp_resd_i = SW'(1);
    samp_last_i = 1'b1;
    #1;
    chk("idle_ready", samp_ready_o, 0);
    cyc(2);
    samp_valid_i = 1'b0;
    samp_last_i = 1'b0;
    chk("idle_cnt", samp_cnt_o, 0);
    chk("idle_data_nonzero", nonzero(), 0);

    // Single-beat vectors
    for (int v = 0; v < 3; v++) begin
      do_init(vt[v].mode);
      chk("vec_mode", affine_param6_o, vt[v].mode);
      chk("vec_cnt_after_init", samp_cnt_o, 0);
      send_beat(vt[v].a, SW'(vt[v].b), 1'b1, 1'b1);
      wait_done();
      chk("vec_a00", el(0, 0), vt[v].e_a00);
      chk("vec_a25", el(2, 5), vt[v].e_a25);
      chk("vec_a52", el(5, 2), vt[v].e_a25);
      chk("vec_a55", el(5, 5), vt[v].e_a55);
      chk("vec_a22", el(2, 2), vt[v].e_a22);
      chk("vec_b0", el(0, 6), vt[v].e_b0);
      chk("vec_b3", el(3, 6), vt[v].e_b3);
      chk("vec_b5", el(5, 6), vt[v].e_b5);
      chk("vec_cnt", samp_cnt_o, 1);
      cyc(1);
      chk("done_width", comp_done_o, 0);
      cyc(3);
      chk("hold_stable", mism(last_exp, fk), 0);
    end

    // Three beats with bubbles, extreme operands
    do_init(1'b1);
    send_beat(mk(-1, 0, 0, 0, 0, 32767), SW'(-32768), 1'b0, 1'b1);
    chk("bub_cnt1", samp_cnt_o, 1);
    cyc(2);
    send_beat(mk(-1, 0, 0, 0, 0, 32767), SW'(-32768), 1'b0, 1'b1);
    cyc(3);
    send_beat(mk(-1, 0, 0, 0, 0, 32767), SW'(-32768), 1'b1, 1'b1);
    wait_done();
    chk("bub_a00", el(0, 0), 3);
    chk("bub_a05", el(0, 5), -98301);
    chk("bub_a50", el(5, 0), -98301);
    chk("bub_a55", el(5, 5), 64'sd3221028867);
    chk("bub_b5", el(5, 6), -64'sd3221127168);
    chk("bub_cnt", samp_cnt_o, 3);
    cyc(2);

    // Restart mid-block with a beat in flight and one colliding with init
    do_init(1'b1);
    dc = done_count;
    send_beat(mk(1, 2, 3, 4, 5, 6), SW'(7), 1'b0, 1'b0);
    comp_init_i = 1'b1;
    affine_param6_i = 1'b1;
    samp_valid_i = 1'b1;
    samp_coef_i = mk(2, 2, 2, 2, 2, 2);
    samp_resd_i = SW'(3);
    samp_last_i = 1'b1;
    #1;
    chk("restart_ready", samp_ready_o, 0);
    cyc(1);
    comp_init_i = 1'b0;
    affine_param6_i = 1'b0;
    samp_valid_i = 1'b0;
    samp_last_i = 1'b0;
    mdl_clear(1'b1);
    chk("restart_data_nonzero", nonzero(), 0);
    chk("restart_cnt", samp_cnt_o, 0);
    chk("restart_done", comp_done_o, 0);
    cyc(3);
    chk("restart_inflight_nonzero", nonzero(), 0);
    chk("restart_no_done", done_count, dc);
    send_beat(mk(0, 0, 1, -2, 3, -4), SW'(5), 1'b1, 1'b1);
    wait_done();
    chk("restart_a35", el(3, 5), 8);
    cyc(2);

    // Counter saturation: 20 beats, 4-bit counter
    do_init(1'b1);
    for (int n = 0; n < 20; n++) send_beat(mk(1, 1, 1, 1, 1, 1), SW'(1), n == 19, 1'b1);
    wait_done();
    chk("sat_cnt", samp_cnt_o, 15);
    chk("sat_a31", el(3, 1), 20);
    chk("sat_a00", el(0, 0), 20);
    chk("sat_b4", el(4, 6), 20);
    cyc(2);

    // Init during FLUSH suppresses the pulse
    do_init(1'b1);
    dc = done_count;
    send_beat(mk(1, 2, 3, 4, 5, 6), SW'(7), 1'b1, 1'b0);
    comp_init_i = 1'b1;
    affine_param6_i = 1'b0;
    cyc(1);
    comp_init_i = 1'b0;
    mdl_clear(1'b0);
    chk("flush_init_done", comp_done_o, 0);
    chk("flush_init_mode", affine_param6_o, 0);
    cyc(3);
    chk("flush_init_no_done", done_count, dc);
    chk("flush_init_data_nonzero", nonzero(), 0);

    // Asynchronous reset during FLUSH
    do_init(1'b1);
    dc = done_count;
    send_beat(mk(3, 1, 4, 1, 5, 9), SW'(2), 1'b1, 1'b0);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst_done", comp_done_o, 0);
    chk("arst_cnt", samp_cnt_o, 0);
    chk("arst_mode", affine_param6_o, 0);
    chk("arst_ready", samp_ready_o, 0);
    chk("arst_data_nonzero", nonzero(), 0);
    cyc(1);
    chk("arst_done_e1", comp_done_o, 0);
    cyc(1);
    rst_n_i = 1'b1;
    cyc(2);
    chk("arst_no_done", done_count, dc);
    chk("arst_state_idle", samp_ready_o, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
